// File: rtl/sub_bytes_engine_pkg.sv
// sub_bytes_engine_pkg: AES S-box tables, FSM encoding and configuration check
package sub_bytes_engine_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  // Entry x is the leftmost-first byte x of each table.
  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  function automatic bit cfg_ok(int nb, int l);
    return (l == 1 || l == 2 || l == 4 || l == 8 || l == 16) && nb > 0 && nb % l == 0;
  endfunction
endpackage

// File: rtl/sub_bytes_engine_if.sv
// sub_bytes_engine_if: valid/ready state stream carrying a mode bit alongside the data
interface sub_bytes_engine_if #(parameter int W = 128);
  logic         valid;
  logic         ready;
  logic         inv;
  logic [W-1:0] data;
  modport master (output valid, data, inv, input ready);
  modport slave (input valid, data, inv, output ready);
endinterface

// File: rtl/sub_bytes_engine_sbox_lane.sv
// aes_sbox_lane: one combinational forward/inverse S-box byte lookup
module aes_sbox_lane
  import sub_bytes_engine_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [7:0] byte_in,
  input  logic       inv,
  output logic [7:0] byte_out
);
  // With INV_EN=0 the inverse branch is constant-false and the table is pruned.
  assign byte_out = (INV_EN && inv) ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];
endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: time-multiplexed AES SubBytes/InvSubBytes over valid/ready streams
module sub_bytes_engine
  import sub_bytes_engine_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4,
  parameter bit INV_EN    = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  sub_bytes_engine_if.slave  in_if,
  sub_bytes_engine_if.master out_if,
  output logic               busy_o
);
  localparam int N  = NUM_BYTES / LANES;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (!cfg_ok(NUM_BYTES, LANES)) begin : g_bad_cfg
    $error("sub_bytes_engine: LANES must be 1/2/4/8/16 and divide NUM_BYTES");
  end
  typedef logic [N-1:0][LANES-1:0][7:0] work_t;
  state_e                 st_q;
  work_t                  work_q, work_d;
  logic [8*NUM_BYTES-1:0] out_q;
  logic [CW-1:0]          cnt_q;
  logic                   mode_q, rdy_q, valid_q;
  logic [LANES-1:0][7:0]  lane_out;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    aes_sbox_lane #(.INV_EN(INV_EN)) u_lane (
      .byte_in (work_q[cnt_q][i]),
      .inv     (mode_q),
      .byte_out(lane_out[i])
    );
  end
  always_comb begin
    work_d        = work_q;
    work_d[cnt_q] = lane_out;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (st_q)
        IDLE: begin
          rdy_q <= 1'b1;
          if (in_if.valid && rdy_q) begin
            work_q <= in_if.data;
            mode_q <= INV_EN && in_if.inv;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
            st_q   <= RUN;
          end
        end
        RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) begin
            out_q   <= work_d;
            valid_q <= 1'b1;
            st_q    <= DONE;
          end
        end
        DONE: begin
          if (out_if.ready) begin
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            st_q    <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign in_if.ready  = rdy_q;
  assign out_if.valid = valid_q;
  assign out_if.data  = out_q;
  assign out_if.inv   = mode_q;
  assign busy_o       = st_q != IDLE;
endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed checks of three engine configurations
module tb_sub_bytes_engine;
  import sub_bytes_engine_pkg::*;
  localparam logic [127:0] V1  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] E1  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
  localparam logic [127:0] S63 = {16{8'h63}};
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic         iv [3];
  logic         iinv [3];
  logic         ordy [3];
  logic [127:0] idat [3];
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];
  logic         bz [3];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  sub_bytes_engine_if #(.W(128)) a_in (), a_out (), b_in (), b_out (), c_in (), c_out ();
  sub_bytes_engine u_dut0 (.clk(clk), .rst_n(rst_n), .in_if(a_in), .out_if(a_out), .busy_o(bz[0]));
  sub_bytes_engine #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .in_if(b_in), .out_if(b_out), .busy_o(bz[1]));
  sub_bytes_engine #(.LANES(16), .INV_EN(1'b0)) u_dut2 (.clk(clk), .rst_n(rst_n), .in_if(c_in), .out_if(c_out), .busy_o(bz[2]));
  assign a_in.valid = iv[0];
  assign a_in.data  = idat[0];
  assign a_in.inv   = iinv[0];
  assign a_out.ready = ordy[0];
  assign b_in.valid = iv[1];
  assign b_in.data  = idat[1];
  assign b_in.inv   = iinv[1];
  assign b_out.ready = ordy[1];
  assign c_in.valid = iv[2];
  assign c_in.data  = idat[2];
  assign c_in.inv   = iinv[2];
  assign c_out.ready = ordy[2];
  assign ir[0] = a_in.ready;
  assign ir[1] = b_in.ready;
  assign ir[2] = c_in.ready;
  assign ov[0] = a_out.valid;
  assign ov[1] = b_out.valid;
  assign ov[2] = c_out.valid;
  assign od[0] = a_out.data;
  assign od[1] = b_out.data;
  assign od[2] = c_out.data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int t = 0;
    while (ir[d] !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  // Sends one block, scrambles the inputs during RUN, returns the result and latency.
  task automatic process(input int d, input logic [127:0] data, input logic inv,
                         output logic [127:0] res, output int lat);
    lat = 0;
    wait_ready(d);
    idat[d] = data; iinv[d] = inv; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0; idat[d] = ~data; iinv[d] = ~inv;
    while (ov[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = od[d];
    @(posedge clk); #1;
  endtask

  initial begin
    logic [127:0] res, din, exp;
    logic [127:0] bdat [3];
    logic [127:0] bexp [3];
    logic [127:0] bres [3];
    logic         binv [3];
    logic         bad_v, bad_d, bad_r, acc;
    int lat, k, nres;
    int acc_t [3];
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; iinv[d] = 1'b0; ordy[d] = 1'b1; idat[d] = '0;
    end
    #2;
    chk("rst_in_ready", 128'(ir[0]), 0);
    chk("rst_out_valid", 128'(ov[0]), 0);
    chk("rst_busy", 128'(bz[0]), 0);
    chk("rst_out_data", od[0], 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", 128'(ir[0]), 1);
    process(0, V1, 1'b0, res, lat);
    chk("fwd_vec", res, E1);
    chk("fwd_latency", 128'(lat), 4);
    process(0, E1, 1'b1, res, lat);
    chk("inv_vec", res, V1);
    process(0, '0, 1'b0, res, lat);
    chk("fwd_zero", res, S63);
    process(0, S63, 1'b1, res, lat);
    chk("inv_63", res, 0);
    ordy[0] = 1'b0;
    wait_ready(0);
    idat[0] = V1; iinv[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    k = 0;
    while (ov[0] !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    bad_v = 1'b0; bad_d = 1'b0; bad_r = 1'b0;
    for (int c = 0; c < 10; c++) begin
      iv[0] = 1'b1; idat[0] = {4{$urandom}}; iinv[0] = c[0];
      @(posedge clk); #1;
      bad_v |= ov[0] !== 1'b1;
      bad_d |= od[0] !== E1;
      bad_r |= ir[0] !== 1'b0;
    end
    iv[0] = 1'b0;
    chk("bp_valid_held", 128'(bad_v), 0);
    chk("bp_data_stable", 128'(bad_d), 0);
    chk("bp_ready_low", 128'(bad_r), 0);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 128'(ov[0]), 0);
    chk("bp_release_busy", 128'(bz[0]), 0);
    chk("bp_release_ready", 128'(ir[0]), 1);
    chk("bp_data_hold", od[0], E1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_extra", 128'(ov[0]), 0);
    wait_ready(0);
    idat[0] = V1; iinv[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 128'(ov[0]), 0);
    chk("rst_mid_data", od[0], 0);
    chk("rst_mid_busy", 128'(bz[0]), 0);
    chk("rst_mid_ready", 128'(ir[0]), 0);
    #3 rst_n = 1'b1;
    process(0, '0, 1'b0, res, lat);
    chk("post_rst_fwd", res, S63);
    for (int b = 0; b < 16; b++) begin
      for (int i = 0; i < 16; i++) begin
        din[8*i +: 8] = 8'(b * 16 + i);
        exp[8*i +: 8] = SBOX_FWD[b * 16 + i];
      end
      process(1, din, 1'b0, res, lat);
      chk("l1_fwd", res, exp);
      if (b == 0) chk("l1_latency", 128'(lat), 16);
      for (int i = 0; i < 16; i++) exp[8*i +: 8] = SBOX_INV[b * 16 + i];
      process(1, din, 1'b1, res, lat);
      chk("l1_inv", res, exp);
      for (int i = 0; i < 16; i++) exp[8*i +: 8] = SBOX_FWD[b * 16 + i];
      process(2, din, 1'b1, res, lat);
      chk("l16_noinv", res, exp);
      if (b == 0) chk("l16_latency", 128'(lat), 1);
    end
    bdat = '{V1, E1, 128'h0};
    binv = '{1'b0, 1'b1, 1'b0};
    bexp = '{E1, V1, S63};
    bres = '{128'h0, 128'h0, 128'h0};
    acc_t = '{0, 0, 0};
    k = 0; nres = 0;
    ordy[0] = 1'b1;
    wait_ready(0);
    idat[0] = bdat[0]; iinv[0] = binv[0]; iv[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = iv[0] & ir[0];
      @(posedge clk); #1;
      if (acc && k < 3) begin
        acc_t[k] = c;
        k++;
        if (k < 3) begin
          idat[0] = bdat[k]; iinv[0] = binv[k];
        end else iv[0] = 1'b0;
      end
      if (ov[0] === 1'b1 && nres < 3) begin
        bres[nres] = od[0];
        nres++;
      end
    end
    chk("b2b_accepts", 128'(k), 3);
    chk("b2b_results", 128'(nres), 3);
    chk("b2b_gap0", 128'(acc_t[1] - acc_t[0]), 6);
    chk("b2b_gap1", 128'(acc_t[2] - acc_t[1]), 6);
    for (int i = 0; i < 3; i++) chk("b2b_data", bres[i], bexp[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
